// File: rtl/hps_cmd_pkg.sv
// Shared types and constants for the HPS PIO command responder.
package hps_cmd_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_RUN   = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_RSP,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;
  localparam logic [1:0] ST_ERR  = 2'b11;

  localparam int OP_LSB    = 0;
  localparam int OP_MSB    = 1;
  localparam int ADDR_LSB  = 2;
  localparam int ADDR_MSB  = 18;
  localparam int WDATA_LSB = 19;
  localparam int WDATA_MSB = 26;
  localparam int RSVD_LSB  = 27;
  localparam int RSVD_MSB  = 31;

  localparam logic [31:0] TMO_SENTINEL = 32'hFFFF_FFFF;

endpackage

// File: rtl/hps_cmd_responder.sv
// Decodes HPS PIO instruction words into one back-end command/response
// transaction each and reports result plus status back through the PIOs.
module hps_cmd_responder
  import hps_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ADDR_W         = 17
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [31:0]       instrucao,
  input  logic [1:0]        act_ins,
  output logic [31:0]       data_out,
  output logic [1:0]        wait_s,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [1:0]        cmd_op,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [7:0]        cmd_wdata,
  input  logic              rsp_valid,
  input  logic [31:0]       rsp_data
);

  state_e      state;
  logic        start_prev;
  logic [31:0] tmo_cnt;

  op_e                          instr_op;
  logic [ADDR_MSB-ADDR_LSB:0]   instr_addr;
  logic [WDATA_MSB-WDATA_LSB:0] instr_wdata;
  logic                         unused_rsvd;
  logic                         start_rise;
  logic [31:0]                  tmo_next;
  logic                         tmo_hit;

  assign instr_op    = op_e'(instrucao[OP_MSB:OP_LSB]);
  assign instr_addr  = instrucao[ADDR_MSB:ADDR_LSB];
  assign instr_wdata = instrucao[WDATA_MSB:WDATA_LSB];
  assign unused_rsvd = ^instrucao[RSVD_MSB:RSVD_LSB];

  assign start_rise = act_ins[0] & ~start_prev;

  // The count after this edge is compared, so ERR is entered exactly
  // TIMEOUT_CYCLES edges after the command was issued.
  assign tmo_next = tmo_cnt + 32'd1;
  assign tmo_hit  = (TIMEOUT_CYCLES != 0) && (tmo_next == 32'(TIMEOUT_CYCLES));

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state      <= S_IDLE;
      start_prev <= 1'b0;
      tmo_cnt    <= '0;
      data_out   <= '0;
      wait_s     <= ST_IDLE;
      cmd_valid  <= 1'b0;
      cmd_op     <= '0;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
    end else begin
      start_prev <= act_ins[0];
      if (act_ins[1]) begin
        state     <= S_IDLE;
        wait_s    <= ST_IDLE;
        cmd_valid <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_rise) begin
              cmd_op    <= instr_op;
              cmd_addr  <= ADDR_W'(instr_addr);
              cmd_wdata <= instr_wdata;
              if (instr_op == OP_NOP) begin
                data_out <= '0;
                wait_s   <= ST_DONE;
                state    <= S_DONE;
              end else begin
                cmd_valid <= 1'b1;
                wait_s    <= ST_BUSY;
                tmo_cnt   <= '0;
                state     <= S_ISSUE;
              end
            end
          end
          S_ISSUE: begin
            tmo_cnt <= tmo_next;
            if (tmo_hit) begin
              data_out  <= TMO_SENTINEL;
              wait_s    <= ST_ERR;
              cmd_valid <= 1'b0;
              state     <= S_ERR;
            end else if (cmd_ready) begin
              cmd_valid <= 1'b0;
              state     <= S_WAIT_RSP;
            end
          end
          S_WAIT_RSP: begin
            tmo_cnt <= tmo_next;
            // A response landing on the timeout edge still counts as in time.
            if (rsp_valid) begin
              data_out <= rsp_data;
              wait_s   <= ST_DONE;
              state    <= S_DONE;
            end else if (tmo_hit) begin
              data_out <= TMO_SENTINEL;
              wait_s   <= ST_ERR;
              state    <= S_ERR;
            end
          end
          S_DONE, S_ERR: begin
            if (!act_ins[0]) begin
              wait_s <= ST_IDLE;
              state  <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hps_cmd_responder.sv
// Scenario bench for hps_cmd_responder with a result scoreboard.
module tb_hps_cmd_responder;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instrucao;
  logic [1:0]  act_ins;
  logic [31:0] data_out;
  logic [1:0]  wait_s;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [16:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  st;
  } exp_t;
  exp_t sb[$];

  hps_cmd_responder #(.TIMEOUT_CYCLES(TMO), .ADDR_W(17)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .instrucao(instrucao), .act_ins(act_ins),
    .data_out(data_out), .wait_s(wait_s), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk_instr(input logic [1:0] op, input logic [16:0] addr,
                                           input logic [7:0] wd);
    return {5'b0, wd, addr, op};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a done/error status, then checks it against the scoreboard head.
  task automatic wait_done(input string name);
    exp_t e;
    int   n = 0;
    while (!wait_s[1] && n < 40) begin
      tick();
      n++;
    end
    vectors++;
    if (!wait_s[1]) begin
      miscompares++;
      $display("FAIL %s_done_timeout: wait_s=%b after %0d cycles, required 1x", name, wait_s, n);
    end
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL %s_sb_empty: no expected entry queued", name);
    end else begin
      e = sb.pop_front();
      vectors += 2;
      if (data_out !== e.data) begin
        miscompares++;
        $display("FAIL %s_data: got %h required %h", name, data_out, e.data);
      end
      if (wait_s !== e.st) begin
        miscompares++;
        $display("FAIL %s_status: got %b required %b", name, wait_s, e.st);
      end
    end
  endtask

  task automatic release_start(input string name);
    act_ins = 2'b00;
    tick();
    vectors++;
    if (wait_s !== 2'b00) begin
      miscompares++;
      $display("FAIL %s_release: wait_s got %b required 00", name, wait_s);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; instrucao = '0; act_ins = 2'b00; cmd_ready = 1'b0;
    rsp_valid = 1'b0; rsp_data = '0;
    repeat (2) tick();
    vectors += 6;
    if (data_out !== 32'h0) begin miscompares++; $display("FAIL reset_data: got %h required 0", data_out); end
    if (wait_s !== 2'b00) begin miscompares++; $display("FAIL reset_wait: got %b required 00", wait_s); end
    if (cmd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b required 0", cmd_valid); end
    if (cmd_op !== 2'b00) begin miscompares++; $display("FAIL reset_op: got %b required 00", cmd_op); end
    if (cmd_addr !== 17'h0) begin miscompares++; $display("FAIL reset_addr: got %h required 0", cmd_addr); end
    if (cmd_wdata !== 8'h0) begin miscompares++; $display("FAIL reset_wdata: got %h required 0", cmd_wdata); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_read();
    instrucao = 32'h0000_48D2; cmd_ready = 1'b1; act_ins = 2'b01;
    sb.push_back('{data: 32'h0000_00AB, st: 2'b10});
    tick();
    vectors += 4;
    if (wait_s !== 2'b01) begin miscompares++; $display("FAIL read_busy: got %b required 01", wait_s); end
    if (cmd_valid !== 1'b1) begin miscompares++; $display("FAIL read_valid: got %b required 1", cmd_valid); end
    if (cmd_op !== 2'b10) begin miscompares++; $display("FAIL read_op: got %b required 10", cmd_op); end
    if (cmd_addr !== 17'h1234) begin miscompares++; $display("FAIL read_addr: got %h required 1234", cmd_addr); end
    tick();
    cmd_ready = 1'b0;
    vectors += 2;
    if (cmd_valid !== 1'b0) begin miscompares++; $display("FAIL read_hs_drop: got %b required 0", cmd_valid); end
    if (wait_s !== 2'b01) begin miscompares++; $display("FAIL read_wait_rsp: got %b required 01", wait_s); end
    repeat (2) tick();
    rsp_valid = 1'b1; rsp_data = 32'h0000_00AB;
    tick();
    rsp_valid = 1'b0; rsp_data = '0;
    wait_done("read");
    release_start("read");
    vectors++;
    if (data_out !== 32'h0000_00AB) begin miscompares++; $display("FAIL read_data_hold: got %h required 000000ab", data_out); end
  endtask

  task automatic test_write();
    instrucao = mk_instr(2'b01, 17'd5, 8'h7F); cmd_ready = 1'b0; act_ins = 2'b01;
    sb.push_back('{data: 32'h1234_5678, st: 2'b10});
    tick();
    for (int i = 0; i < 5; i++) begin
      vectors += 4;
      if (cmd_valid !== 1'b1) begin miscompares++; $display("FAIL write_valid_%0d: got %b required 1", i, cmd_valid); end
      if (cmd_op !== 2'b01) begin miscompares++; $display("FAIL write_op_%0d: got %b required 01", i, cmd_op); end
      if (cmd_addr !== 17'd5) begin miscompares++; $display("FAIL write_addr_%0d: got %h required 5", i, cmd_addr); end
      if (cmd_wdata !== 8'h7F) begin miscompares++; $display("FAIL write_wdata_%0d: got %h required 7f", i, cmd_wdata); end
      if (i < 4) tick();
    end
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    vectors++;
    if (cmd_valid !== 1'b0) begin miscompares++; $display("FAIL write_hs_drop: got %b required 0", cmd_valid); end
    rsp_valid = 1'b1; rsp_data = 32'h1234_5678;
    tick();
    rsp_valid = 1'b0;
    wait_done("write");
    release_start("write");
  endtask

  task automatic test_nop();
    instrucao = 32'hF800_0000; act_ins = 2'b01;
    sb.push_back('{data: 32'h0, st: 2'b10});
    tick();
    vectors += 2;
    if (wait_s !== 2'b10) begin miscompares++; $display("FAIL nop_done_next: got %b required 10", wait_s); end
    if (cmd_valid !== 1'b0) begin miscompares++; $display("FAIL nop_valid: got %b required 0", cmd_valid); end
    wait_done("nop");
    release_start("nop");
  endtask

  task automatic test_timeout();
    instrucao = mk_instr(2'b10, 17'h00100, 8'h00); cmd_ready = 1'b1; act_ins = 2'b01;
    tick();
    cmd_ready = 1'b0;
    repeat (TMO - 1) tick();
    vectors++;
    if (wait_s !== 2'b01) begin miscompares++; $display("FAIL tmo_early: got %b required 01", wait_s); end
    sb.push_back('{data: 32'hFFFF_FFFF, st: 2'b11});
    tick();
    vectors++;
    if (cmd_valid !== 1'b0) begin miscompares++; $display("FAIL tmo_valid: got %b required 0", cmd_valid); end
    wait_done("timeout");
    rsp_valid = 1'b1; rsp_data = 32'h0000_0042;
    tick();
    rsp_valid = 1'b0;
    vectors += 2;
    if (data_out !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL tmo_late_rsp: got %h required ffffffff", data_out); end
    if (wait_s !== 2'b11) begin miscompares++; $display("FAIL tmo_hold: got %b required 11", wait_s); end
    release_start("timeout");
  endtask

  task automatic test_abort();
    logic [31:0] prev;
    prev = data_out;
    instrucao = mk_instr(2'b10, 17'h00ABC, 8'h00); cmd_ready = 1'b1; act_ins = 2'b01;
    tick();
    tick();
    cmd_ready = 1'b0;
    act_ins = 2'b11; rsp_valid = 1'b1; rsp_data = 32'h0000_0055;
    tick();
    rsp_valid = 1'b0; act_ins = 2'b01;
    vectors += 3;
    if (wait_s !== 2'b00) begin miscompares++; $display("FAIL abort_wait: got %b required 00", wait_s); end
    if (cmd_valid !== 1'b0) begin miscompares++; $display("FAIL abort_valid: got %b required 0", cmd_valid); end
    if (data_out !== prev) begin miscompares++; $display("FAIL abort_data: got %h required %h", data_out, prev); end
    repeat (4) tick();
    vectors += 2;
    if (wait_s !== 2'b00) begin miscompares++; $display("FAIL abort_retrig_wait: got %b required 00", wait_s); end
    if (cmd_valid !== 1'b0) begin miscompares++; $display("FAIL abort_retrig_valid: got %b required 0", cmd_valid); end
    release_start("abort");
  endtask

  task automatic test_no_retrigger();
    instrucao = 32'h0; act_ins = 2'b01;
    sb.push_back('{data: 32'h0, st: 2'b10});
    tick();
    wait_done("held_nop");
    instrucao = mk_instr(2'b11, 17'd3, 8'h00);
    repeat (3) tick();
    vectors += 2;
    if (wait_s !== 2'b10) begin miscompares++; $display("FAIL held_wait: got %b required 10", wait_s); end
    if (cmd_valid !== 1'b0) begin miscompares++; $display("FAIL held_valid: got %b required 0", cmd_valid); end
    release_start("held");
    act_ins = 2'b01; cmd_ready = 1'b1;
    sb.push_back('{data: 32'hCAFE_0003, st: 2'b10});
    tick();
    vectors += 3;
    if (cmd_valid !== 1'b1) begin miscompares++; $display("FAIL retrig_valid: got %b required 1", cmd_valid); end
    if (cmd_op !== 2'b11) begin miscompares++; $display("FAIL retrig_op: got %b required 11", cmd_op); end
    if (cmd_addr !== 17'd3) begin miscompares++; $display("FAIL retrig_addr: got %h required 3", cmd_addr); end
    tick();
    cmd_ready = 1'b0;
    rsp_valid = 1'b1; rsp_data = 32'hCAFE_0003;
    tick();
    rsp_valid = 1'b0;
    wait_done("retrig");
    release_start("retrig");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      logic [16:0] a;
      logic [31:0] d;
      a = 17'($urandom_range(0, 76799));
      d = $urandom;
      instrucao = mk_instr(2'b10, a, 8'h00); act_ins = 2'b01; cmd_ready = 1'b1;
      sb.push_back('{data: d, st: 2'b10});
      tick();
      vectors += 2;
      if (cmd_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid_%0d: got %b required 1", k, cmd_valid); end
      if (cmd_addr !== a) begin miscompares++; $display("FAIL b2b_addr_%0d: got %h required %h", k, cmd_addr, a); end
      tick();
      cmd_ready = 1'b0;
      rsp_valid = 1'b1; rsp_data = d;
      tick();
      rsp_valid = 1'b0;
      wait_done("b2b");
      release_start("b2b");
    end
  endtask

  task automatic test_reset_mid();
    instrucao = mk_instr(2'b01, 17'h1FFFF, 8'hEE); act_ins = 2'b01; cmd_ready = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    vectors += 4;
    if (cmd_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_valid: got %b required 0", cmd_valid); end
    if (wait_s !== 2'b00) begin miscompares++; $display("FAIL rstmid_wait: got %b required 00", wait_s); end
    if (cmd_addr !== 17'h0) begin miscompares++; $display("FAIL rstmid_addr: got %h required 0", cmd_addr); end
    if (data_out !== 32'h0) begin miscompares++; $display("FAIL rstmid_data: got %h required 0", data_out); end
    act_ins = 2'b00;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_nop();
    test_timeout();
    test_abort();
    test_no_retrigger();
    test_back_to_back();
    test_reset_mid();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_leftover: %0d entries left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hps_cmd_responder.md
# hps_cmd_responder

FPGA-side responder for the HPS-to-coprocessor PIO command channel. It accepts 32-bit instruction words and activate bits written by the HPS through the `instrucao`/`act_ins` PIO exports. It decodes each instruction and drives one transaction on the coprocessor back-end command/response interface. It returns the result and status to the HPS through the `data`/`wait_s` PIO exports. It sits in the top level between `soc_system` and the image-filter coprocessor datapath.

## Interface
- `TIMEOUT_CYCLES`, default 1024: maximum number of cycles from command issue to response. A value of 0 disables the timeout.
- `ADDR_W`, default 17: pixel address width (covers 320x240).
- `clk_clk` in 1: system clock. The PIOs share this domain.
- `reset_reset_n` in 1: reset, asynchronous and active-low.
- `instrucao` in 32: instruction word from the HPS PIO.
- `act_ins` in 2: bit 0 is the start level; bit 1 is abort.
- `data_out` out 32: result word to the HPS `data` PIO.
- `wait_s` out 2: status to the HPS `wait_s` PIO.
  - 00 idle
  - 01 busy
  - 10 done
  - 11 error/timeout
- `cmd_valid` out 1: back-end command request.
- `cmd_ready` in 1: back-end accepts the command.
- `cmd_op` out 2: decoded opcode.
- `cmd_addr` out ADDR_W: pixel address, or filter select for the RUN opcode.
- `cmd_wdata` out 8: pixel write data.
- `rsp_valid` in 1: single-cycle back-end response strobe.
- `rsp_data` in 32: response payload.

## Operation
- Instruction fields:
  - op = `instrucao`[1:0]
  - addr = `instrucao`[18:2]
  - wdata = `instrucao`[26:19]
  - bits [31:27] are reserved and ignored.
- Opcodes:
  - 00 NOP: no back-end traffic; data_out = 0.
  - 01 WRITE pixel.
  - 10 READ pixel.
  - 11 RUN filter: addr[2:0] selects the kernel.
- States: IDLE, ISSUE, WAIT_RSP, DONE, ERR.
- IDLE:
  - A rising edge of `act_ins[0]` (registered previous value 0, current value 1) latches `instrucao` into an internal register.
  - NOP goes directly to DONE.
  - Any other opcode goes to ISSUE.
  - A level of `act_ins[0]` that stays high does not retrigger.
- ISSUE: `cmd_valid`=1 with stable cmd_* fields. When `cmd_valid && cmd_ready` at an edge, go to WAIT_RSP.
- WAIT_RSP: on `rsp_valid`, capture `data_out` <= `rsp_data` and go to DONE. WRITE and RUN also require an `rsp_valid` acknowledge; their payload is returned unchanged.
- DONE / ERR: hold `data_out` and `wait_s`. When `act_ins[0]`==0, go to IDLE and set `wait_s` to 00. `data_out` keeps its last value.
- Timeout:
  - The counter clears on entry to ISSUE and increments every cycle in ISSUE or WAIT_RSP.
  - When it reaches TIMEOUT_CYCLES: go to ERR, set `data_out` to 32'hFFFF_FFFF, drop `cmd_valid`.
- Abort (`act_ins[1]`=1):
  - From any state, go to IDLE at the next edge.
  - Set `wait_s`=00 and `cmd_valid`=0.
  - Abort has priority over start and over a `rsp_valid` or timeout in the same cycle.
  - The start-edge register still updates, so a start held high through an abort does not fire afterwards.
- `rsp_valid` outside WAIT_RSP is ignored.
- `cmd_ready` outside ISSUE is ignored.

## Timing
- All outputs are registered.
- Reset values: `data_out`=0, `wait_s`=00, `cmd_valid`=0, `cmd_op`=0, `cmd_addr`=0, `cmd_wdata`=0. Reset also clears the state to IDLE, the edge register to 0 and the timeout counter to 0.
- Start sampled at edge N: `wait_s`=01 and `cmd_valid`=1 are visible after edge N.
- NOP: `wait_s`=10 after edge N.
- Handshake at edge H: `cmd_valid`=0 after H. Minimum one cycle in ISSUE.
- `rsp_valid` at edge M: `data_out` and `wait_s`=10 after M. Minimum latency from start to done is 2 edges plus back-end latency.
- Timeout: ERR is entered at the edge where count == TIMEOUT_CYCLES.
- `act_ins[0]` low sampled at edge K in DONE/ERR: `wait_s`=00 after K. A new start needs `act_ins[0]` to go low and then high again; the earliest retrigger is edge K+1.
- Reset asserted mid-transaction: immediate return to reset values with no response.

## Structure
- Package `hps_cmd_pkg`:
  - opcode enum (NOP/WRITE/READ/RUN)
  - state enum
  - `wait_s` encodings (ST_IDLE, ST_BUSY, ST_DONE, ST_ERR)
  - instruction field LSB/MSB constants
  - timeout sentinel 32'hFFFF_FFFF
- Single module; no sub-module. Decode is a few field slices.

## Test plan
- READ at addr 0x1234: instrucao=0x0000_48D2, `act_ins`=01, back-end ready at once and `rsp_valid` 3 cycles later with 0x0000_00AB. Expect `cmd_op`=10, `cmd_addr`=0x1234, `wait_s` 01 then 10, `data_out`=0xAB; after `act_ins`=00, `wait_s`=00.
- WRITE pixel 0x7F at addr 5: `cmd_wdata`=0x7F, `cmd_addr`=5. With `cmd_ready` held low 4 cycles, `cmd_valid` stays high and the fields stay stable for 4 cycles. Done after the ack.
- NOP: `wait_s`=10 one edge after the start, `cmd_valid` never asserts, `data_out`=0.
- TIMEOUT_CYCLES=8 with no `rsp_valid`: `wait_s`=11 and `data_out`=0xFFFF_FFFF at the 8th edge. A late `rsp_valid` is ignored.
- Abort in WAIT_RSP, with `act_ins`=11 together with `rsp_valid`: next state IDLE, `wait_s`=00, `data_out` unchanged. Holding `act_ins`=01 afterwards does not retrigger.
- `act_ins[0]` held high after DONE with a new instrucao written: no new command until `act_ins[0]` toggles 0 then 1.
